hci_core_source_linear: RTL and testbench
=========================================

Name: hci_core_source_linear

Overview:
Read-side streamer. Fetches a linear, strided sequence of words from TCDM over the HCI core request/grant/r_valid protocol and emits them as an HWPE stream. Pairs with the store-side sink on the same accelerator port. Has an internal linear address generator, a credit-limited response FIFO and byte realignment of misaligned base addresses.

Parameters:
DATA_WIDTH, 64, TCDM word and stream data width in bits; multiple of 32.
LEN_WIDTH, 16, width of the transfer length field.
RESP_FIFO_DEPTH, 4, response FIFO depth and maximum outstanding-plus-buffered words; power of 2, at least 2.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
clear_i  in  1  synchronous clear of all state
enable_i  in  1  global enable; low freezes FSM, issue and pop
start_i  in  1  start request, sampled only in IDLE
base_addr_i  in  32  byte start address
stride_i  in  32  byte stride between words
len_i  in  LEN_WIDTH  number of words to fetch
ready_start_o  out  1  high in IDLE
busy_o  out  1  high when not IDLE
done_o  out  1  one-cycle pulse at transfer end
tcdm_req_o  out  1  TCDM request
tcdm_gnt_i  in  1  TCDM grant
tcdm_add_o  out  32  word-aligned address
tcdm_wen_o  out  1  constant 1 (read)
tcdm_be_o  out  DATA_WIDTH/8  constant all-ones
tcdm_r_valid_i  in  1  read response valid, exactly 1 cycle after gnt
tcdm_r_data_i  in  DATA_WIDTH  read data
stream_valid_o  out  1  stream valid
stream_ready_i  in  1  stream ready
stream_data_o  out  DATA_WIDTH  realigned data
stream_strb_o  out  DATA_WIDTH/8  valid-byte strobe
perf_stall_cnt_o  out  32  grant-stall cycle count (see Optional Feature)

Behaviour:
- Reset: FSM in IDLE; all counters and FIFO cleared; ready_start_o=1; all other outputs 0.
- FSM states are IDLE, WORKING and DRAIN.
- IDLE: if start_i and len_i!=0, latch base, stride and len; addr_q=base; go to WORKING.
- IDLE, start_i with len_i==0: stay in IDLE; done_o pulses the next cycle.
- WORKING: tcdm_req_o = enable_i & (issued<len) & (credit<RESP_FIFO_DEPTH).
  - credit = granted-but-not-returned count plus FIFO occupancy.
  - On req&gnt: addr_q += stride, modulo 2^32 wrap; issued++; latch addr_q[1:0] as off_q.
  - After the grant that makes issued==len, go to DRAIN.
- Request stability: once req is high without gnt, req, add and be stay stable until gnt. Exception: enable_i falling may drop req.
- tcdm_add_o = {addr_q[31:2],2'b00}.
- Response path:
  - On tcdm_r_valid_i, push {data, off_q} into the FIFO regardless of enable_i. Credit guarantees there is no overflow.
  - stream_data_o = head_data >> (8*off).
  - stream_strb_o = all-ones >> off. Upper bytes and strobe bits are zero.
- stream_valid_o = enable_i & FIFO not empty. A pop on valid&ready increments popped.
- DRAIN: when popped==len, go to IDLE and pulse done_o in that same cycle.
- Counters are LEN_WIDTH wide. Credit is $clog2(RESP_FIFO_DEPTH)+1 bits wide.
- Simultaneous push and pop in the same cycle: occupancy unchanged.
- Simultaneous grant, response and pop in the same cycle: credit updated by +1-1.
- start_i outside IDLE is ignored.
- clear_i: next cycle IDLE, FIFO flushed, counters zeroed, no done_o. clear_i wins over start_i.
- Any response arriving after clear_i is dropped.
- Asynchronous reset mid-transfer behaves as clear_i.
- Latency: first request in the cycle after start_i. First stream beat 2 cycles after the first grant (response, then FIFO output).

Optional Feature:
HCI_SOURCE_PERF_CNT_EN
- Defined: perf_stall_cnt_o counts cycles with tcdm_req_o&~tcdm_gnt_i.
  - Cleared on an accepted start and on clear_i.
  - Saturates at 0xFFFFFFFF.
- Undefined: the port is present and tied to 0, and no counter logic is instantiated.

Test Plan:
1. base=0x1000, stride=8, len=4, gnt=1, ready=1 -> tcdm_add_o is 0x1000, 0x1008, 0x1010, 0x1018 on 4 consecutive cycles; 4 stream beats in order; single done_o pulse; back in IDLE.
2. base=0x1002, stride=4, len=1, r_data=0xAABBCCDD11223344 -> add=0x1000; stream_data_o=0x0000AABBCCDD1122; strb=0x3F.
3. len=10, RESP_FIFO_DEPTH=4, stream_ready_i=0 -> exactly 4 grants, then req held low. Raise ready -> remaining 6 issued; all 10 beats in order; done_o once.
4. gnt=0 for 3 cycles on first request -> req and add stable throughout. With the macro defined, perf_stall_cnt_o=3 at done_o.
5. clear_i after 2 grants with responses pending -> IDLE next cycle; stream_valid_o=0; no done_o. A new start with len=2 completes normally.
6. start_i with len_i=0 -> no tcdm_req_o; done_o high exactly 1 cycle, one cycle later. Base 0xFFFFFFF8, stride 8, len=2 -> second address 0x00000000.

Source files
------------

// File: rtl/hci_core_source_linear.sv
// Read-side TCDM streamer: strided linear fetch over HCI core, credit-limited response FIFO,
// byte realignment of misaligned bases. Optional stall counter: HCI_SOURCE_PERF_CNT_EN.
module hci_core_source_linear #(
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned LEN_WIDTH       = 16,
  parameter int unsigned RESP_FIFO_DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    enable_i,
  input  logic                    start_i,
  input  logic [31:0]             base_addr_i,
  input  logic [31:0]             stride_i,
  input  logic [LEN_WIDTH-1:0]    len_i,
  output logic                    ready_start_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    tcdm_req_o,
  input  logic                    tcdm_gnt_i,
  output logic [31:0]             tcdm_add_o,
  output logic                    tcdm_wen_o,
  output logic [DATA_WIDTH/8-1:0] tcdm_be_o,
  input  logic                    tcdm_r_valid_i,
  input  logic [DATA_WIDTH-1:0]   tcdm_r_data_i,
  output logic                    stream_valid_o,
  input  logic                    stream_ready_i,
  output logic [DATA_WIDTH-1:0]   stream_data_o,
  output logic [DATA_WIDTH/8-1:0] stream_strb_o,
  output logic [31:0]             perf_stall_cnt_o
);

  localparam int unsigned BeW  = DATA_WIDTH / 8;
  localparam int unsigned PtrW = $clog2(RESP_FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StWorking, StDrain} state_e;

  state_e                r_state, w_state_d;
  logic [31:0]           r_addr, r_stride;
  logic [LEN_WIDTH-1:0]  r_len, r_issued, r_popped;
  logic [1:0]            r_off;
  logic [CntW-1:0]       r_credit, r_count;
  logic [PtrW-1:0]       r_wptr, r_rptr;
  logic                  r_drop, r_done_zero;
  logic [DATA_WIDTH-1:0] r_fifo_data [RESP_FIFO_DEPTH];
  logic [1:0]            r_fifo_off  [RESP_FIFO_DEPTH];

  logic w_start_ok, w_start_zero, w_req, w_gnt_acc, w_push, w_empty, w_valid, w_pop;
  logic w_drain_done;
  logic [BeW-1:0] w_strb_all;

  assign w_start_ok   = enable_i & start_i & ~clear_i & (r_state == StIdle) & (len_i != '0);
  assign w_start_zero = enable_i & start_i & ~clear_i & (r_state == StIdle) & (len_i == '0);
  assign w_req        = (r_state == StWorking) & enable_i & (r_issued < r_len) &
                        (r_credit < CntW'(RESP_FIFO_DEPTH));
  assign w_gnt_acc    = w_req & tcdm_gnt_i;
  // The response to a grant issued in the clear cycle lands one cycle later; r_drop masks it.
  assign w_push       = tcdm_r_valid_i & ~r_drop & ~clear_i;
  assign w_empty      = (r_count == '0);
  assign w_valid      = enable_i & ~w_empty;
  assign w_pop        = w_valid & stream_ready_i;
  assign w_drain_done = (r_state == StDrain) & enable_i & (r_popped == r_len);

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:    if (w_start_ok) w_state_d = StWorking;
      StWorking: if (w_gnt_acc && (r_issued + LEN_WIDTH'(1) == r_len)) w_state_d = StDrain;
      StDrain:   if (w_drain_done) w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
    if (clear_i) w_state_d = StIdle;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= StIdle;
      r_addr      <= '0;
      r_stride    <= '0;
      r_len       <= '0;
      r_issued    <= '0;
      r_popped    <= '0;
      r_off       <= '0;
      r_credit    <= '0;
      r_count     <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_drop      <= 1'b1;
      r_done_zero <= 1'b0;
    end else if (clear_i) begin
      r_state     <= StIdle;
      r_addr      <= '0;
      r_stride    <= '0;
      r_len       <= '0;
      r_issued    <= '0;
      r_popped    <= '0;
      r_off       <= '0;
      r_credit    <= '0;
      r_count     <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_drop      <= 1'b1;
      r_done_zero <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_drop      <= 1'b0;
      r_done_zero <= w_start_zero;
      if (w_start_ok) begin
        r_addr   <= base_addr_i;
        r_stride <= stride_i;
        r_len    <= len_i;
        r_issued <= '0;
        r_popped <= '0;
      end
      if (w_gnt_acc) begin
        r_addr   <= r_addr + r_stride;
        r_issued <= r_issued + LEN_WIDTH'(1);
        r_off    <= r_addr[1:0];
      end
      if (w_pop)  r_popped <= r_popped + LEN_WIDTH'(1);
      if (w_push) r_wptr   <= r_wptr + PtrW'(1);
      if (w_pop)  r_rptr   <= r_rptr + PtrW'(1);
      // Credit covers in-flight plus buffered words, so a response never finds the FIFO full.
      r_credit <= r_credit + CntW'(w_gnt_acc) - CntW'(w_pop);
      r_count  <= r_count + CntW'(w_push) - CntW'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_data[r_wptr] <= tcdm_r_data_i;
      r_fifo_off[r_wptr]  <= r_off;
    end
  end

  assign w_strb_all = '1;

  always_comb begin
    stream_data_o = '0;
    stream_strb_o = '0;
    if (!w_empty) begin
      stream_data_o = r_fifo_data[r_rptr] >> {r_fifo_off[r_rptr], 3'b000};
      stream_strb_o = w_strb_all >> r_fifo_off[r_rptr];
    end
  end

  assign stream_valid_o = w_valid;
  assign tcdm_req_o     = w_req;
  assign tcdm_add_o     = {r_addr[31:2], 2'b00};
  assign tcdm_wen_o     = 1'b1;
  assign tcdm_be_o      = '1;
  assign ready_start_o  = (r_state == StIdle);
  assign busy_o         = (r_state != StIdle);
  assign done_o         = r_done_zero | w_drain_done;

`ifdef HCI_SOURCE_PERF_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_cnt <= '0;
    end else if (clear_i || w_start_ok) begin
      r_stall_cnt <= '0;
    end else if (w_req && !tcdm_gnt_i && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt_o = r_stall_cnt;
`else
  assign perf_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hci_core_source_linear.sv
// Directed bench for hci_core_source_linear: TCDM responder, queue-based expected-stream model
// and per-cycle grant/beat comparison, plus literal checks from hand-worked vectors.
module tb_hci_core_source_linear;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear, enable, start;
  logic [31:0] base_addr, stride;
  logic [15:0] len;
  logic        ready_start, busy, done;
  logic        tcdm_req, tcdm_gnt, tcdm_wen, tcdm_r_valid;
  logic [31:0] tcdm_add, perf;
  logic [7:0]  tcdm_be, stream_strb;
  logic [63:0] tcdm_r_data, stream_data;
  logic        stream_valid, stream_ready;

  logic        gnt_allow;
  logic        ovr_en;
  logic [63:0] ovr_data;

  always #5 clk = ~clk;

  hci_core_source_linear #(
    .DATA_WIDTH(64), .LEN_WIDTH(16), .RESP_FIFO_DEPTH(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .enable_i(enable), .start_i(start),
    .base_addr_i(base_addr), .stride_i(stride), .len_i(len),
    .ready_start_o(ready_start), .busy_o(busy), .done_o(done),
    .tcdm_req_o(tcdm_req), .tcdm_gnt_i(tcdm_gnt), .tcdm_add_o(tcdm_add),
    .tcdm_wen_o(tcdm_wen), .tcdm_be_o(tcdm_be),
    .tcdm_r_valid_i(tcdm_r_valid), .tcdm_r_data_i(tcdm_r_data),
    .stream_valid_o(stream_valid), .stream_ready_i(stream_ready),
    .stream_data_o(stream_data), .stream_strb_o(stream_strb),
    .perf_stall_cnt_o(perf)
  );

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    if (ovr_en) return ovr_data;
    return {~a, a ^ 32'h5A5A_5A5A};
  endfunction

  // TCDM responder: data returns exactly one cycle after the grant.
  assign tcdm_gnt = tcdm_req & gnt_allow;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcdm_r_valid <= 1'b0;
      tcdm_r_data  <= '0;
    end else begin
      tcdm_r_valid <= tcdm_req & tcdm_gnt;
      tcdm_r_data  <= mem_word(tcdm_add);
    end
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_data_q[$];
  logic [7:0]  exp_strb_q[$];
  logic [31:0] grant_log[$];
  int cyc = 0, start_cyc = 0;
  int grant_cnt = 0, beat_cnt = 0, done_cnt = 0, stall_model = 0;
  int first_grant_cyc = 0, last_grant_cyc = 0, first_beat_cyc = 0;
  logic [63:0] first_beat_data;
  logic [7:0]  first_beat_strb;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_add = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        check("req_stable", tcdm_req, 1'b1);
        check("add_stable", tcdm_add, prev_add);
      end
      if (tcdm_req && !tcdm_gnt) stall_model++;
      if (tcdm_req && tcdm_gnt) begin
        if (grant_cnt == 0) first_grant_cyc = cyc;
        last_grant_cyc = cyc;
        grant_cnt++;
        grant_log.push_back(tcdm_add);
        if (exp_addr_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_grant: add=0x%0h with no request expected", tcdm_add);
        end else check("tcdm_add", tcdm_add, exp_addr_q.pop_front());
      end
      if (stream_valid && stream_ready) begin
        if (beat_cnt == 0) begin
          first_beat_cyc  = cyc;
          first_beat_data = stream_data;
          first_beat_strb = stream_strb;
        end
        beat_cnt++;
        if (exp_data_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_beat: data=0x%0h with no beat expected", stream_data);
        end else begin
          check("stream_data", stream_data, exp_data_q.pop_front());
          check("stream_strb", stream_strb, exp_strb_q.pop_front());
        end
      end
      if (done) done_cnt++;
      prev_stall = tcdm_req & ~tcdm_gnt;
      prev_add   = tcdm_add;
      cyc++;
    end
  end

  task automatic clear_counts();
    grant_cnt = 0; beat_cnt = 0; done_cnt = 0; stall_model = 0;
    grant_log.delete();
  endtask

  task automatic start_xfer(input logic [31:0] b, input logic [31:0] s, input int n);
    logic [31:0] a, w;
    for (int i = 0; i < n; i++) begin
      a = b + s * 32'(i);
      w = {a[31:2], 2'b00};
      exp_addr_q.push_back(w);
      exp_data_q.push_back(mem_word(w) >> (8 * a[1:0]));
      exp_strb_q.push_back(8'hFF >> a[1:0]);
    end
    clear_counts();
    start_cyc = cyc;
    base_addr = b; stride = s; len = n[15:0]; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (done_cnt == 0) begin
      n_checks++;
      $display("FAIL %s_timeout: no done_o within %0d cycles", name, budget);
    end
    repeat (3) @(posedge clk);
    #1;
    check({name, "_done_once"}, done_cnt, 1);
    check({name, "_idle"}, ready_start, 1'b1);
    check({name, "_beats_left"}, exp_data_q.size(), 0);
    check({name, "_addrs_left"}, exp_addr_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clear = 0; enable = 1; start = 0; base_addr = 0; stride = 0; len = 0;
    stream_ready = 1; gnt_allow = 1; ovr_en = 0; ovr_data = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready_start", ready_start, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_req", tcdm_req, 1'b0);
    check("rst_valid", stream_valid, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_perf", perf, 0);
    @(posedge clk); #1;

    // 1: aligned stride-8 fetch, full-throughput
    start_xfer(32'h1000, 32'd8, 4);
    wait_done(40, "t1");
    check("t1_add0", grant_log[0], 32'h1000);
    check("t1_add1", grant_log[1], 32'h1008);
    check("t1_add2", grant_log[2], 32'h1010);
    check("t1_add3", grant_log[3], 32'h1018);
    check("t1_grant_span", last_grant_cyc - first_grant_cyc, 3);
    check("t1_req_latency", first_grant_cyc - start_cyc, 1);
    check("t1_beat_latency", first_beat_cyc - first_grant_cyc, 2);
    check("t1_beats", beat_cnt, 4);

    // 2: misaligned base realignment
    ovr_en = 1; ovr_data = 64'hAABBCCDD11223344;
    start_xfer(32'h1002, 32'd4, 1);
    wait_done(20, "t2");
    check("t2_add", grant_log[0], 32'h1000);
    check("t2_data", first_beat_data, 64'h0000AABBCCDD1122);
    check("t2_strb", first_beat_strb, 8'h3F);
    ovr_en = 0;

    // 3: credit limit with back-pressure
    stream_ready = 0;
    start_xfer(32'h2000, 32'd4, 10);
    repeat (12) @(posedge clk);
    #1;
    check("t3_grants_capped", grant_cnt, 4);
    check("t3_req_low", tcdm_req, 1'b0);
    check("t3_valid_held", stream_valid, 1'b1);
    stream_ready = 1;
    wait_done(80, "t3");
    check("t3_grants", grant_cnt, 10);
    check("t3_beats", beat_cnt, 10);

    // 4: grant stall on the first request
    gnt_allow = 0;
    start_xfer(32'h3000, 32'd16, 2);
    repeat (3) @(posedge clk);
    #1 gnt_allow = 1;
    wait_done(30, "t4");
    check("t4_stall_cycles", stall_model, 3);
`ifdef HCI_SOURCE_PERF_CNT_EN
    check("t4_perf", perf, 3);
`else
    check("t4_perf_tied", perf, 0);
`endif

    // 5: clear with responses in flight
    stream_ready = 0;
    start_xfer(32'h4000, 32'd8, 4);
    @(posedge clk); #1;
    clear = 1;
    @(posedge clk); #1;
    clear = 0;
    exp_addr_q.delete(); exp_data_q.delete(); exp_strb_q.delete();
    check("t5_idle", ready_start, 1'b1);
    check("t5_busy", busy, 1'b0);
    check("t5_valid_after_clear", stream_valid, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("t5_valid_late", stream_valid, 1'b0);
    check("t5_no_done", done_cnt, 0);
    check("t5_grants", grant_cnt, 2);
    stream_ready = 1;
    start_xfer(32'h5000, 32'd4, 2);
    wait_done(30, "t5b");

    // 6: zero-length start, then address wrap
    clear_counts();
    len = 0; start = 1;
    @(negedge clk);
    check("t6_done_c0", done, 1'b0);
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    check("t6_done_c1", done, 1'b1);
    @(negedge clk);
    check("t6_done_c2", done, 1'b0);
    check("t6_no_req", grant_cnt + stall_model, 0);
    check("t6_idle", ready_start, 1'b1);
    @(posedge clk); #1;
    start_xfer(32'hFFFF_FFF8, 32'd8, 2);
    wait_done(30, "t6w");
    check("t6_wrap_add0", grant_log[0], 32'hFFFF_FFF8);
    check("t6_wrap_add1", grant_log[1], 32'h0000_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
